// File: rtl/ymux_pkg.sv
// Shared definitions for the ymux_rr_arb registered arbitrating multiplexer.
//   MODE_RR    : round-robin arbitration (pointer advances on each accepted word)
//   MODE_FIXED : fixed priority, lowest channel index wins
//   onehot2idx : converts a one-hot vector (up to 32 bits) to its bit index
package ymux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // OR-reduction of the set bit positions. The argument is one-hot or zero,
    // so no priority chain is needed. A zero vector maps to index 0.
    function automatic int onehot2idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ymux_rr_pick.sv
// Combinational grant picker for ymux_rr_arb.
//   req     in   N      request vector (channel valid bits)
//   last    in   SELW   index of the most recently granted channel
//   gnt     out  N      one-hot grant, zero when req is zero
//   gnt_idx out  SELW   index of the granted channel
// Round-robin searches last+1, last+2, ... wrapping; fixed mode ignores last
// and grants the lowest requesting index.
module ymux_rr_pick
    import ymux_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_first;

    // Low half holds only requests above the pointer; high half holds all of
    // them. The lowest set bit of the concatenation is therefore the first
    // requester after the pointer, falling back to the wrapped search.
    // In fixed mode the mask is empty, which leaves a plain lowest-index pick.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (MODE == MODE_RR) && (i > int'(last));
        end
        dbl       = {req, req & mask};
        dbl_first = dbl & ~(dbl - (2*N)'(1));
        gnt       = dbl_first[2*N-1:N] | dbl_first[N-1:0];
        gnt_idx   = SELW'(onehot2idx(32'(gnt)));
    end

endmodule

// File: rtl/ymux_rr_arb.sv
// Registered N-channel arbitrating multiplexer with valid/ready on every port.
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   in_data    in   N*SIZE  channel i at bits [i*SIZE +: SIZE]
//   in_valid   in   N       channel i offers data
//   in_ready   out  N       channel i accepted this cycle (one-hot or zero)
//   out_data   out  SIZE    registered data of the accepted channel
//   out_sel    out  SELW    channel index held in out_data
//   out_valid  out  1       out_data is valid
//   out_ready  in   1       consumer takes out_data this cycle
// A single output register is loaded whenever it is empty or draining, so
// back-to-back transfers run at one word per cycle.
module ymux_rr_arb
    import ymux_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    parameter int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N*SIZE-1:0] in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [SIZE-1:0]   out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic            can_load;
    logic            load;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] gnt_idx;
    logic [SELW-1:0] last;
    logic [SIZE-1:0] mux_data;

    assign can_load = !out_valid || out_ready;
    assign load     = can_load && (|in_valid);
    assign in_ready = gnt & {N{can_load}};

    ymux_rr_pick #(
        .N    (N),
        .MODE (MODE),
        .SELW (SELW)
    ) u_pick (
        .req     (in_valid),
        .last    (last),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // AND-OR mux: only the granted channel contributes, so an X on an idle
    // channel never reaches the register.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[i*SIZE +: SIZE] & {SIZE{gnt[i]}});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SELW'(N - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_sel   <= gnt_idx;
            if (MODE == MODE_RR) begin
                last <= gnt_idx;
            end
        end else if (out_ready) begin
            // Reaching here with out_ready set means no channel was valid.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ymux_rr_arb.sv
module tb_ymux_rr_arb;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // round-robin, N=4, SIZE=32
    logic [127:0] a_data = '0;
    logic [3:0]   a_valid = '0;
    logic [3:0]   a_ready;
    logic [31:0]  a_odata;
    logic [1:0]   a_sel;
    logic         a_ov;
    logic         a_ordy = 1'b0;

    // fixed priority, N=4, SIZE=32
    logic [127:0] b_data = '0;
    logic [3:0]   b_valid = '0;
    logic [3:0]   b_ready;
    logic [31:0]  b_odata;
    logic [1:0]   b_sel;
    logic         b_ov;
    logic         b_ordy = 1'b0;

    // round-robin, N=16, SIZE=8
    logic [127:0] c_data = '0;
    logic [15:0]  c_valid = '0;
    logic [15:0]  c_ready;
    logic [7:0]   c_odata;
    logic [3:0]   c_sel;
    logic         c_ov;
    logic         c_ordy = 1'b0;

    ymux_rr_arb #(.SIZE(32), .N(4), .MODE(0)) dut_rr (
        .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .out_data(a_odata), .out_sel(a_sel),
        .out_valid(a_ov), .out_ready(a_ordy));

    ymux_rr_arb #(.SIZE(32), .N(4), .MODE(1)) dut_fx (
        .clk(clk), .reset_n(reset_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .out_data(b_odata), .out_sel(b_sel),
        .out_valid(b_ov), .out_ready(b_ordy));

    ymux_rr_arb #(.SIZE(8), .N(16), .MODE(0)) dut_big (
        .clk(clk), .reset_n(reset_n), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .out_data(c_odata), .out_sel(c_sel),
        .out_valid(c_ov), .out_ready(c_ordy));

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] rdy;   // expected in_ready before the edge
        logic       ov;    // expected out_valid after the edge
        logic [1:0] sel;   // expected out_sel after the edge
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] cw  [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // scoreboard state for the 16-channel sweep
    logic [11:0] q [$];
    logic [11:0] item;
    int          m_last;
    int          rel;
    int          g;
    int          wcnt [16];
    int          max_wait;
    logic        exp_ov;
    logic        can_ld;
    logic [15:0] exp_rdy;

    initial begin
        cw[0] = 32'h1111_0000;
        cw[1] = 32'h2222_0001;
        cw[2] = 32'hDEAD_BEEF;
        cw[3] = 32'h4444_0003;
        a_data = {cw[3], cw[2], cw[1], cw[0]};
        b_data = {cw[3], cw[2], cw[1], cw[0]};

        //          iv      ordy  rdy      ov    sel
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};  // drain
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};  // idle
        tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};  // load DEADBEEF
        tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};  // stall x3
        tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[11] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};  // pointer was frozen at 2
        tbl[12] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[13] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[14] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_ov", 64'(a_ov), 64'(0));
        chk("rst_sel", 64'(a_sel), 64'(0));
        chk("rst_data", 64'(a_odata), 64'(0));
        chk("rst_big_ov", 64'(c_ov), 64'(0));

        // table-driven round-robin vectors
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            a_valid = tbl[k].iv;
            a_ordy  = tbl[k].ordy;
            #1;
            chk($sformatf("tbl%0d_rdy", k), 64'(a_ready), 64'(tbl[k].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ov", k), 64'(a_ov), 64'(tbl[k].ov));
            chk($sformatf("tbl%0d_sel", k), 64'(a_sel), 64'(tbl[k].sel));
            chk($sformatf("tbl%0d_data", k), 64'(a_odata), 64'(cw[tbl[k].sel]));
        end

        // fixed priority: channel 1 always beats channel 3
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b_valid = 4'b1010;
            b_ordy  = 1'b1;
            #1;
            chk($sformatf("fx%0d_rdy", k), 64'(b_ready), 64'(4'b0010));
            @(posedge clk);
            #1;
            chk($sformatf("fx%0d_sel", k), 64'(b_sel), 64'(1));
            chk($sformatf("fx%0d_data", k), 64'(b_odata), 64'(cw[1]));
        end
        @(negedge clk);
        b_valid = '0;

        // reset asserted between edges while a word is held
        a_valid = 4'b1111;
        a_ordy  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_ov", 64'(a_ov), 64'(0));
        chk("midrst_data", 64'(a_odata), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("postrst_rdy", 64'(a_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        chk("postrst_sel", 64'(a_sel), 64'(0));
        chk("postrst_ov", 64'(a_ov), 64'(1));
        @(negedge clk);
        a_valid = '0;

        // random sweep on the 16-channel instance
        m_last   = 15;
        rel      = -1;
        max_wait = 0;
        for (int i = 0; i < 16; i++) wcnt[i] = 0;
        for (int it = 0; it < 500; it++) begin
            @(negedge clk);
            if (rel >= 0) c_valid[rel] = 1'b0;
            rel = -1;
            for (int i = 0; i < 16; i++) begin
                if (!c_valid[i] && $urandom_range(0, 99) < 40) begin
                    c_valid[i] = 1'b1;
                    c_data[i*8 +: 8] = 8'($urandom);
                    wcnt[i] = 0;
                end
            end
            c_ordy = ($urandom_range(0, 99) < 70);
            #1;
            exp_ov = (q.size() != 0);
            chk("rnd_ov", 64'(c_ov), 64'(exp_ov));
            if (exp_ov && c_ordy) begin
                item = q.pop_front();
                chk("rnd_sel", 64'(c_sel), 64'(item[11:8]));
                chk("rnd_data", 64'(c_odata), 64'(item[7:0]));
            end
            can_ld = !exp_ov || c_ordy;
            g = -1;
            if (can_ld) begin
                for (int s = 1; s <= 16; s++) begin
                    if (g < 0 && c_valid[(m_last + s) % 16]) g = (m_last + s) % 16;
                end
            end
            exp_rdy = (g >= 0) ? (16'(1) << g) : 16'(0);
            chk("rnd_rdy", 64'(c_ready), 64'(exp_rdy));
            if (g >= 0) begin
                q.push_back({4'(g), c_data[g*8 +: 8]});
                m_last = g;
                rel    = g;
                for (int i = 0; i < 16; i++) begin
                    if (i != g && c_valid[i]) begin
                        wcnt[i]++;
                        if (wcnt[i] > max_wait) max_wait = wcnt[i];
                    end
                end
                wcnt[g] = 0;
            end
        end
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            if (rel >= 0) c_valid[rel] = 1'b0;
            rel     = -1;
            c_valid = '0;
            c_ordy  = 1'b1;
            #1;
            exp_ov = (q.size() != 0);
            chk("flush_ov", 64'(c_ov), 64'(exp_ov));
            if (exp_ov) begin
                item = q.pop_front();
                chk("flush_sel", 64'(c_sel), 64'(item[11:8]));
                chk("flush_data", 64'(c_odata), 64'(item[7:0]));
            end
        end
        chk("sb_empty", 64'(q.size()), 64'(0));
        chk("max_wait_le_15", 64'(max_wait <= 15), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
